// File: rtl/muldiv_iter.sv
`timescale 1ns/1ps
// muldiv_iter -- iterative RV32M multiply/divide unit.
//
// Accepts one M-extension operation per request, computes it one bit per
// clock (shift-add multiply, restoring divide) and presents a registered
// result with a one-cycle done pulse. Divide-by-zero and signed overflow
// bypass the iteration and finish in a single cycle.
//
// Ports:
//   iCLK        in   clock, rising edge
//   iRST_n      in   asynchronous active-low reset
//   iStart      in   request, sampled only in IDLE or DONE
//   iALUControl in   decoder ALU control code (OP* encodings)
//   iA, iB      in   rs1 / rs2 operands
//   oBusy       out  high while iterating or fixing up the result
//   oDone       out  one-cycle pulse, oResult valid in this cycle
//   oResult     out  result register, held until the next accepted start
module muldiv_iter #(
  parameter int DATA_W     = 32,
  parameter bit ENABLE_MUL = 1'b1
) (
  input  logic              iCLK,
  input  logic              iRST_n,
  input  logic              iStart,
  input  logic [4:0]        iALUControl,
  input  logic [DATA_W-1:0] iA,
  input  logic [DATA_W-1:0] iB,
  output logic              oBusy,
  output logic              oDone,
  output logic [DATA_W-1:0] oResult
);

  localparam logic [4:0] OPMUL    = 5'd11;
  localparam logic [4:0] OPMULH   = 5'd12;
  localparam logic [4:0] OPMULHSU = 5'd13;
  localparam logic [4:0] OPMULHU  = 5'd14;
  localparam logic [4:0] OPDIV    = 5'd15;
  localparam logic [4:0] OPDIVU   = 5'd16;
  localparam logic [4:0] OPREM    = 5'd17;
  localparam logic [4:0] OPREMU   = 5'd18;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  function automatic logic [DATA_W-1:0] abs_val(input logic signed [DATA_W-1:0] v,
                                                input logic take);
    return take ? -v : v;
  endfunction

  function automatic logic [DATA_W-1:0] cond_neg_w(input logic [DATA_W-1:0] v,
                                                   input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*DATA_W-1:0] cond_neg_2w(input logic [2*DATA_W-1:0] v,
                                                      input logic neg);
    return neg ? -v : v;
  endfunction

  state_t            state_q;
  logic [4:0]        cnt_q;
  logic [4:0]        op_q;
  logic              neg_q;
  // r_q: partial remainder (divide) or product high half (multiply)
  // x_q: dividend->quotient shifter (divide) or multiplier->product low half
  // y_q: divisor (divide) or multiplicand (multiply)
  logic [DATA_W-1:0] r_q, x_q, y_q;
  logic              busy_q, done_q;
  logic [DATA_W-1:0] res_q;

  logic              is_mul_d, is_div_d, is_rem_d, sa_d, sb_d, neg_d;
  logic              accept_d, dz_d, ovf_d, fast_d;
  logic [DATA_W-1:0] abs_a_d, abs_b_d, fast_res_d;

  // Request decode and operand preparation for the accept edge
  always_comb begin
    is_mul_d = ENABLE_MUL && (iALUControl inside {OPMUL, OPMULH, OPMULHSU, OPMULHU});
    is_div_d = iALUControl inside {OPDIV, OPDIVU, OPREM, OPREMU};
    is_rem_d = iALUControl inside {OPREM, OPREMU};
    accept_d = iStart && (state_q == S_IDLE || state_q == S_DONE) && (is_mul_d || is_div_d);
    sa_d     = iA[DATA_W-1] && (iALUControl inside {OPDIV, OPREM, OPMULH, OPMULHSU});
    sb_d     = iB[DATA_W-1] && (iALUControl inside {OPDIV, OPREM, OPMULH});
    // Remainder takes the dividend's sign; everything else the xor of both
    neg_d    = is_rem_d ? sa_d : (sa_d ^ sb_d);
    abs_a_d  = abs_val(iA, sa_d);
    abs_b_d  = abs_val(iB, sb_d);
    dz_d     = is_div_d && (iB == '0);
    ovf_d    = (iALUControl == OPDIV || iALUControl == OPREM) &&
               (iA == {1'b1, {(DATA_W-1){1'b0}}}) && (&iB);
    fast_d   = dz_d || ovf_d;
    if (dz_d)
      fast_res_d = (iALUControl == OPDIV || iALUControl == OPDIVU) ? '1 : iA;
    else
      fast_res_d = (iALUControl == OPDIV) ? {1'b1, {(DATA_W-1){1'b0}}} : '0;
  end

  logic              mul_op_d;
  logic [DATA_W:0]   shift_d, diff_d, sum_d;
  logic [2*DATA_W-1:0] prod_d;
  logic [DATA_W-1:0] quo_d, rem_d, fix_res_d;

  // One iteration step and final sign fix-up
  always_comb begin
    mul_op_d = ENABLE_MUL && (op_q inside {OPMUL, OPMULH, OPMULHSU, OPMULHU});
    // Restoring divide: bring in the next dividend bit, trial-subtract
    shift_d  = {r_q, x_q[DATA_W-1]};
    diff_d   = shift_d - {1'b0, y_q};
    // Shift-add multiply, LSB of the multiplier first
    sum_d    = {1'b0, r_q} + (x_q[0] ? {1'b0, y_q} : '0);
    prod_d   = cond_neg_2w({r_q, x_q}, neg_q);
    quo_d    = cond_neg_w(x_q, neg_q);
    rem_d    = cond_neg_w(r_q, neg_q);
    case (op_q)
      OPMUL:                     fix_res_d = prod_d[DATA_W-1:0];
      OPMULH, OPMULHSU, OPMULHU: fix_res_d = prod_d[2*DATA_W-1:DATA_W];
      OPREM, OPREMU:             fix_res_d = rem_d;
      default:                   fix_res_d = quo_d;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      r_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        // Accept stage (E0): latch operands, or finish at once on the fast path
        S_IDLE, S_DONE: begin
          if (accept_d) begin
            op_q  <= iALUControl;
            neg_q <= neg_d;
            if (fast_d) begin
              res_q   <= fast_res_d;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_DONE;
            end else begin
              cnt_q   <= 5'(DATA_W-1);
              r_q     <= '0;
              x_q     <= is_mul_d ? abs_b_d : abs_a_d;
              y_q     <= is_mul_d ? abs_a_d : abs_b_d;
              busy_q  <= 1'b1;
              state_q <= S_CALC;
            end
          end else begin
            state_q <= S_IDLE;
          end
        end
        // Iteration stage (E1..E32)
        S_CALC: begin
          if (mul_op_d) begin
            r_q <= sum_d[DATA_W:1];
            x_q <= {sum_d[0], x_q[DATA_W-1:1]};
          end else if (!diff_d[DATA_W]) begin
            r_q <= diff_d[DATA_W-1:0];
            x_q <= {x_q[DATA_W-2:0], 1'b1};
          end else begin
            r_q <= shift_d[DATA_W-1:0];
            x_q <= {x_q[DATA_W-2:0], 1'b0};
          end
          if (cnt_q == '0) state_q <= S_FIX;
          else             cnt_q   <= cnt_q - 5'd1;
        end
        // Fix-up stage (E33): sign correction and result select
        S_FIX: begin
          res_q   <= fix_res_d;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_DONE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign oBusy   = busy_q;
  assign oDone   = done_q;
  assign oResult = res_q;

endmodule
